alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signal bundle for alu_arbiter
interface alu_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int FUN_W = 4
);
    logic             req_valid_0;
    logic             req_valid_1;
    logic             req_ready_0;
    logic             req_ready_1;
    logic [FUN_W-1:0] req_fun_0;
    logic [FUN_W-1:0] req_fun_1;
    logic [XLEN-1:0]  req_op1_0;
    logic [XLEN-1:0]  req_op1_1;
    logic [XLEN-1:0]  req_op2_0;
    logic [XLEN-1:0]  req_op2_1;

    logic             rsp_valid_0;
    logic             rsp_valid_1;
    logic             rsp_ready_0;
    logic             rsp_ready_1;
    logic [XLEN-1:0]  rsp_data;

    logic [FUN_W-1:0] alu_fun;
    logic [XLEN-1:0]  alu_op1;
    logic [XLEN-1:0]  alu_op2;
    logic [XLEN-1:0]  alu_data;

    logic             busy;

    modport slave (
        input  req_valid_0, req_valid_1, req_fun_0, req_fun_1,
               req_op1_0, req_op1_1, req_op2_0, req_op2_1,
               rsp_ready_0, rsp_ready_1, alu_data,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data,
               alu_fun, alu_op1, alu_op2, busy
    );

    modport master (
        output req_valid_0, req_valid_1, req_fun_0, req_fun_1,
               req_op1_0, req_op1_1, req_op2_0, req_op2_1,
               rsp_ready_0, rsp_ready_1, alu_data,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data,
               alu_fun, alu_op1, alu_op2, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one combinational ALU
module alu_arbiter #(
    parameter int XLEN  = 32,
    parameter int FUN_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             last_grant;
    logic             grant_vld;
    logic             grant_port;
    logic             port_q;
    logic             rsp_hs;
    logic [FUN_W-1:0] fun_q;
    logic [XLEN-1:0]  op1_q;
    logic [XLEN-1:0]  op2_q;
    logic [XLEN-1:0]  result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants exist only in IDLE and never while reset is held, so ready is
    // also the acceptance strobe for the granted port.
    always_comb begin
        state_nxt       = state;
        grant_vld       = 1'b0;
        grant_port      = 1'b0;
        rsp_hs          = 1'b0;
        bus.req_ready_0 = 1'b0;
        bus.req_ready_1 = 1'b0;
        bus.rsp_valid_0 = 1'b0;
        bus.rsp_valid_1 = 1'b0;
        bus.busy        = 1'b1;

        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (!reset) begin
                    if (bus.req_valid_0 && bus.req_valid_1) begin
                        grant_vld  = 1'b1;
                        grant_port = ~last_grant;
                    end else if (bus.req_valid_0) begin
                        grant_vld  = 1'b1;
                        grant_port = 1'b0;
                    end else if (bus.req_valid_1) begin
                        grant_vld  = 1'b1;
                        grant_port = 1'b1;
                    end
                end
                if (grant_vld) begin
                    bus.req_ready_0 = ~grant_port;
                    bus.req_ready_1 = grant_port;
                    state_nxt       = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid_0 = ~port_q;
                bus.rsp_valid_1 = port_q;
                rsp_hs          = port_q ? bus.rsp_ready_1 : bus.rsp_ready_0;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            port_q     <= 1'b0;
            fun_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            result_q   <= '0;
        end else begin
            if (grant_vld) begin
                last_grant <= grant_port;
                port_q     <= grant_port;
                fun_q      <= grant_port ? bus.req_fun_1 : bus.req_fun_0;
                op1_q      <= grant_port ? bus.req_op1_1 : bus.req_op1_0;
                op2_q      <= grant_port ? bus.req_op2_1 : bus.req_op2_0;
            end
            if (state == EXEC) begin
                result_q <= bus.alu_data;
            end
        end
    end

    // ALU inputs come straight from the operand latches so they stay quiet
    // between transactions.
    assign bus.alu_fun  = fun_q;
    assign bus.alu_op1  = op1_q;
    assign bus.alu_op2  = op2_q;
    assign bus.rsp_data = result_q;

endmodule
